// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered UART transmitter (8 data bits, no parity, 1 stop bit).
//
// Bytes written with i_Tx_DV go into a small FIFO. Whenever the serialiser
// is idle and the FIFO holds data, the head byte is popped and sent as a
// start bit, eight data bits (LSB first) and a stop bit. Each bit lasts
// CLKS_PER_BIT clocks.
//
// Ports:
//   clk          - single clock, all logic on the rising edge
//   rst          - synchronous active-high reset
//   i_Tx_DV      - write strobe for i_Tx_Byte
//   i_Tx_Byte    - byte to enqueue
//   o_Tx_Ready   - registered, high while the FIFO has a free entry
//   o_Tx_Serial  - registered serial line, idles high
//   o_Tx_Active  - registered, high while a frame is being sent
//   o_Tx_Done    - registered, one-cycle pulse after each stop bit
//   o_Fifo_Count - buffered bytes, not counting the byte being shifted
module uart_tx_buf #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0]    CLK_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [7:0]      clk_cnt_r, clk_cnt_s;
    logic [2:0]      bit_cnt_r, bit_cnt_s;
    logic [7:0]      shift_r, shift_s;
    logic            serial_r, serial_s;
    logic            active_r, active_s;
    logic            done_r, done_s;

    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r, count_s;
    logic            ready_r, ready_s;
    logic            push_s, pop_s;

    // Pointer advance with explicit wrap from the last entry back to 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Writes are gated by the registered ready flag, so a write that lands in
    // the same cycle a full FIFO is popped is still dropped.
    assign push_s  = i_Tx_DV & ready_r;
    assign count_s = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    assign ready_s = (count_s < DEPTH_C);

    // Next-state and next-output logic for the serialiser. Outputs are
    // registered from the current state, so the line lags the state by one
    // clock.
    always_comb begin
        state_s   = state_r;
        clk_cnt_s = clk_cnt_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        serial_s  = 1'b1;
        active_s  = active_r;
        done_s    = 1'b0;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                clk_cnt_s = 8'd0;
                bit_cnt_s = 3'd0;
                if (count_r != {CW{1'b0}}) begin
                    pop_s    = 1'b1;
                    shift_s  = mem_r[rd_ptr_r];
                    active_s = 1'b1;
                    state_s  = START;
                end else begin
                    active_s = 1'b0;
                end
            end
            START: begin
                serial_s = 1'b0;
                if (clk_cnt_r == CLK_LAST) begin
                    clk_cnt_s = 8'd0;
                    state_s   = DATA;
                end else begin
                    clk_cnt_s = clk_cnt_r + 8'd1;
                end
            end
            DATA: begin
                serial_s = shift_r[bit_cnt_r];
                if (clk_cnt_r == CLK_LAST) begin
                    clk_cnt_s = 8'd0;
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_s = 3'd0;
                        state_s   = STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 8'd1;
                end
            end
            STOP: begin
                if (clk_cnt_r == CLK_LAST) begin
                    clk_cnt_s = 8'd0;
                    state_s   = CLEANUP;
                end else begin
                    clk_cnt_s = clk_cnt_r + 8'd1;
                end
            end
            CLEANUP: begin
                done_s   = 1'b1;
                active_s = 1'b0;
                state_s  = IDLE;
            end
            default: begin
                clk_cnt_s = 8'd0;
                bit_cnt_s = 3'd0;
                active_s  = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // Serialiser state and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            clk_cnt_r <= 8'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            serial_r  <= 1'b1;
            active_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            clk_cnt_r <= clk_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            serial_r  <= serial_s;
            active_r  <= active_s;
            done_r    <= done_s;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_s;
            ready_r <= ready_s;
        end
    end

    // FIFO storage; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_r[wr_ptr_r] <= i_Tx_Byte;
        end
    end

    assign o_Tx_Ready   = ready_r;
    assign o_Tx_Serial  = serial_r;
    assign o_Tx_Active  = active_r;
    assign o_Tx_Done    = done_r;
    assign o_Fifo_Count = count_r;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: self-checking bench for uart_tx_buf (CLKS_PER_BIT=87,
// FIFO_DEPTH=4). A frame-timeline model predicts every output each cycle;
// a behavioural serial receiver decodes the line; directed scenarios add
// hand-computed expectations at specific clock edges.
module tb_uart_tx_buf;

    localparam int C = 87;
    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic       o_Tx_Serial;
    logic       o_Tx_Active;
    logic       o_Tx_Done;
    logic [2:0] o_Fifo_Count;

    uart_tx_buf #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_Tx_DV      (i_Tx_DV),
        .i_Tx_Byte    (i_Tx_Byte),
        .o_Tx_Ready   (o_Tx_Ready),
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done),
        .o_Fifo_Count (o_Fifo_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int rx_cnt   = 0;
    logic [7:0] rx_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- model: buffered bytes plus one frame timeline --------
    // e counts edges since the pop edge: 1..C start, C+1..9C data,
    // 9C+1..10C stop, 10C+1 done pulse, next edge is idle again.
    logic [7:0] q[$];
    logic [7:0] fb;
    bit   busy, m_valid;
    int   e;
    logic m_serial, m_active, m_done;

    initial begin
        busy = 0; m_valid = 0; e = 0;
        m_serial = 1'b1; m_active = 1'b0; m_done = 1'b0; fb = 8'h00;
        forever begin
            bit can_push;
            int bi;
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                busy = 0; e = 0;
                m_serial = 1'b1; m_active = 1'b0; m_done = 1'b0;
                m_valid = 1;
            end else begin
                can_push = (i_Tx_DV === 1'b1) && (q.size() < D);
                if (!busy || e == 10*C + 1) begin
                    busy = 0;
                    m_serial = 1'b1;
                    m_done = 1'b0;
                    if (q.size() > 0) begin
                        fb = q.pop_front();
                        busy = 1; e = 0;
                        m_active = 1'b1;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    e++;
                    if (e <= C) begin
                        m_serial = 1'b0;
                    end else if (e <= 9*C) begin
                        bi = (e - 1) / C - 1;
                        m_serial = fb[bi[2:0]];
                    end else begin
                        m_serial = 1'b1;
                    end
                    m_done   = (e == 10*C + 1);
                    m_active = (e <= 10*C);
                end
                if (can_push) q.push_back(i_Tx_Byte);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (o_Tx_Done === 1'b1) done_cnt++;
            if (m_valid) begin
                chk("serial", 32'(o_Tx_Serial), 32'(m_serial));
                chk("active", 32'(o_Tx_Active), 32'(m_active));
                chk("done",   32'(o_Tx_Done),   32'(m_done));
                chk("count",  32'(o_Fifo_Count), 32'(q.size()));
                chk("ready",  32'(o_Tx_Ready),  32'(q.size() < D));
            end
        end
    end

    // Behavioural receiver: mid-bit sampling, valid frame needs stop = 1.
    initial begin
        forever begin
            logic [7:0] b;
            @(negedge o_Tx_Serial);
            repeat (C/2) @(posedge clk);
            #1;
            if (o_Tx_Serial === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(posedge clk);
                    #1 b[i] = o_Tx_Serial;
                end
                repeat (C) @(posedge clk);
                #1;
                if (o_Tx_Serial === 1'b1) begin
                    rx_q.push_back(b);
                    rx_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(input int k);
        while (cyc < k) step();
        @(negedge clk);
    endtask

    task automatic write(input logic [7:0] b, output int n);
        i_Tx_DV = 1'b1;
        i_Tx_Byte = b;
        step();
        i_Tx_DV = 1'b0;
        n = cyc;
    endtask

    task automatic wait_rx(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic check_rx(input string name, input int idx, input logic [7:0] exp);
        if (idx < rx_q.size()) begin
            chk(name, 32'(rx_q[idx]), 32'(exp));
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: byte missing, expected %0h", name, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n, n2, d0, r0;
        rst = 1'b1; i_Tx_DV = 1'b0; i_Tx_Byte = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_serial", 32'(o_Tx_Serial), 32'd1);
        chk("rst_active", 32'(o_Tx_Active), 32'd0);
        chk("rst_done",   32'(o_Tx_Done),   32'd0);
        chk("rst_ready",  32'(o_Tx_Ready),  32'd1);
        chk("rst_count",  32'(o_Fifo_Count), 32'd0);

        // Single byte 0x55: exact bit timing and done pulse.
        d0 = done_cnt;
        write(8'h55, n);
        chk("t1_count_w", 32'(o_Fifo_Count), 32'd1);
        at_cyc(n+1);   chk("t1_idle_n1", 32'(o_Tx_Serial), 32'd1);
                       chk("t1_pop_cnt", 32'(o_Fifo_Count), 32'd0);
        at_cyc(n+2);   chk("t1_start_n2", 32'(o_Tx_Serial), 32'd0);
        at_cyc(n+88);  chk("t1_start_n88", 32'(o_Tx_Serial), 32'd0);
        at_cyc(n+89);  chk("t1_bit0", 32'(o_Tx_Serial), 32'd1);
        at_cyc(n+176); chk("t1_bit1", 32'(o_Tx_Serial), 32'd0);
        at_cyc(n+784); chk("t1_bit7", 32'(o_Tx_Serial), 32'd0);
        at_cyc(n+785); chk("t1_stop", 32'(o_Tx_Serial), 32'd1);
        at_cyc(n+871); chk("t1_done_n871", 32'(o_Tx_Done), 32'd0);
                       chk("t1_act_n871", 32'(o_Tx_Active), 32'd1);
        at_cyc(n+872); chk("t1_done_n872", 32'(o_Tx_Done), 32'd1);
                       chk("t1_act_n872", 32'(o_Tx_Active), 32'd0);
        at_cyc(n+873); chk("t1_done_n873", 32'(o_Tx_Done), 32'd0);
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        repeat (20) step();

        // Fill and overflow behind an active frame, then a write on the
        // pop edge out of full (ready still low, so it is dropped).
        rx_q.delete();
        write(8'hC3, n);
        at_cyc(n+2);
        chk("t2_active", 32'(o_Tx_Active), 32'd1);
        i_Tx_DV = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            i_Tx_Byte = 8'(i);
            step();
            if (i == 4) begin
                chk("t2_full_count", 32'(o_Fifo_Count), 32'd4);
                chk("t2_full_ready", 32'(o_Tx_Ready), 32'd0);
            end
        end
        i_Tx_DV = 1'b0;
        chk("t2_drop_count", 32'(o_Fifo_Count), 32'd4);
        chk("t2_drop_ready", 32'(o_Tx_Ready), 32'd0);
        at_cyc(n+872);
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h5A;
        step();
        i_Tx_DV = 1'b0;
        chk("t2_popfull_count", 32'(o_Fifo_Count), 32'd3);
        chk("t2_popfull_ready", 32'(o_Tx_Ready), 32'd1);
        wait_rx("t2_rx_n", 5, 5000);
        check_rx("t2_rx0", 0, 8'hC3);
        check_rx("t2_rx1", 1, 8'h01);
        check_rx("t2_rx2", 2, 8'h02);
        check_rx("t2_rx3", 3, 8'h03);
        check_rx("t2_rx4", 4, 8'h04);
        repeat (1000) step();
        chk("t2_no_extra", 32'(rx_q.size()), 32'd5);
        chk("t2_empty", 32'(o_Fifo_Count), 32'd0);

        // Back-to-back: two high cycles between stop and next start.
        rx_q.delete();
        write(8'hA3, n);
        at_cyc(n+4);
        write(8'h3C, n2);
        chk("t3_queued", 32'(o_Fifo_Count), 32'd1);
        at_cyc(n+871); chk("t3_stop_end", 32'(o_Tx_Serial), 32'd1);
        at_cyc(n+872); chk("t3_gap1", 32'(o_Tx_Serial), 32'd1);
                       chk("t3_done", 32'(o_Tx_Done), 32'd1);
        at_cyc(n+873); chk("t3_gap2", 32'(o_Tx_Serial), 32'd1);
                       chk("t3_repop", 32'(o_Tx_Active), 32'd1);
        at_cyc(n+874); chk("t3_start2", 32'(o_Tx_Serial), 32'd0);
        wait_rx("t3_rx_n", 2, 2500);
        check_rx("t3_rx0", 0, 8'hA3);
        check_rx("t3_rx1", 1, 8'h3C);
        repeat (100) step();

        // Simultaneous push and pop keeps the count at 1.
        rx_q.delete();
        write(8'h81, n);
        write(8'h7E, n2);
        chk("t4_pushpop", 32'(o_Fifo_Count), 32'd1);
        at_cyc(n+2);   chk("t4_count_hold", 32'(o_Fifo_Count), 32'd1);
        at_cyc(n+874); chk("t4_start2", 32'(o_Tx_Serial), 32'd0);
        wait_rx("t4_rx_n", 2, 2500);
        check_rx("t4_rx0", 0, 8'h81);
        check_rx("t4_rx1", 1, 8'h7E);
        repeat (100) step();

        // Reset during bit 3 of 0xFF with two bytes queued; a write is
        // offered in the reset cycle too.
        write(8'hFF, n);
        at_cyc(n+4);
        write(8'h11, n2);
        write(8'h22, n2);
        at_cyc(n+379);
        chk("t5_pre_count", 32'(o_Fifo_Count), 32'd2);
        chk("t5_pre_active", 32'(o_Tx_Active), 32'd1);
        d0 = done_cnt;
        rst = 1'b1; i_Tx_DV = 1'b1; i_Tx_Byte = 8'h99;
        step();
        rst = 1'b0; i_Tx_DV = 1'b0;
        @(negedge clk);
        chk("t5_serial", 32'(o_Tx_Serial), 32'd1);
        chk("t5_active", 32'(o_Tx_Active), 32'd0);
        chk("t5_count", 32'(o_Fifo_Count), 32'd0);
        chk("t5_ready", 32'(o_Tx_Ready), 32'd1);
        repeat (1000) step();
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_still_empty", 32'(o_Fifo_Count), 32'd0);

        // Loopback through the receiver.
        rx_q.delete();
        r0 = rx_cnt;
        write(8'h00, n);
        write(8'hFF, n2);
        write(8'h96, n2);
        wait_rx("t6_rx_n", 3, 3500);
        chk("t6_strobes", 32'(rx_cnt - r0), 32'd3);
        check_rx("t6_rx0", 0, 8'h00);
        check_rx("t6_rx1", 1, 8'hFF);
        check_rx("t6_rx2", 2, 8'h96);
        repeat (100) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clock cycles per serial bit, legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4, number of byte entries in the transmit buffer, power of two, legal range 2..16.
REQ-003 Port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-005 Port i_Tx_DV, input, 1 bit, write strobe for i_Tx_Byte.
REQ-006 Port i_Tx_Byte, input, 8 bits, byte to transmit.
REQ-007 Port o_Tx_Ready, output, 1 bit, high when the buffer has space (count < FIFO_DEPTH).
REQ-008 Port o_Tx_Serial, output, 1 bit, registered serial line; it idles high.
REQ-009 Port o_Tx_Active, output, 1 bit, registered; high while a frame is on the line.
REQ-010 Port o_Tx_Done, output, 1 bit, registered; a one-cycle pulse after each stop bit completes.
REQ-011 Port o_Fifo_Count, output, clog2(FIFO_DEPTH)+1 bits, number of buffered bytes, excluding the byte being shifted.

Function
REQ-012 A write is accepted on a clock edge where i_Tx_DV=1 and o_Tx_Ready=1; the count increments on the next cycle.
REQ-013 When i_Tx_DV=1 and o_Tx_Ready=0, the write is dropped: FIFO contents, pointers and count are unchanged.
REQ-014 The FIFO is first-in first-out; read and write pointers wrap from FIFO_DEPTH-1 to 0.
REQ-015 The state machine has states IDLE, START, DATA, STOP and CLEANUP; encodings not listed return to IDLE.
REQ-016 IDLE: o_Tx_Serial=1 and the bit counter is 0. If count>0, pop the head entry into the shift register, set o_Tx_Active=1 and go to START.
REQ-017 START: o_Tx_Serial=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-018 DATA: send bits 0..7, LSB first, each for exactly CLKS_PER_BIT cycles, then go to STOP.
REQ-019 STOP: o_Tx_Serial=1 for exactly CLKS_PER_BIT cycles, then clear o_Tx_Active, pulse o_Tx_Done and go to CLEANUP.
REQ-020 CLEANUP: lasts exactly 1 cycle with o_Tx_Serial=1 and o_Tx_Done=1, then go to IDLE. o_Tx_Done is 0 in all other states.
REQ-021 Latency: a write accepted at edge N into an empty, idle block gives o_Tx_Serial=0 from edge N+2. The frame lasts 10*CLKS_PER_BIT cycles.
REQ-022 Back-to-back frames: with data buffered, the next start bit begins 2 cycles after the stop bit ends (CLEANUP + IDLE). The frame period is 10*CLKS_PER_BIT+2 cycles.
REQ-023 A simultaneous write and pop in the same cycle leaves the count unchanged; both operations take effect.
REQ-024 A write in the same cycle the FIFO transitions from full via pop is accepted only if o_Tx_Ready was already 1 in that cycle. o_Tx_Ready is registered from the count.
REQ-025 The byte being shifted is unaffected by later writes; new writes never alter a frame in progress.
REQ-026 The clock and bit counters are at least 8 and 3 bits wide respectively and never exceed CLKS_PER_BIT-1 and 7.

Reset
REQ-027 When rst=1 at an edge, the block enters IDLE and clears the pointers, count, clock counter and bit counter.
REQ-028 Reset values of the outputs: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, o_Fifo_Count=0.
REQ-029 Reset during a frame aborts it: the line goes high at the next edge and all buffered bytes are discarded.
REQ-030 Writes during a cycle where rst=1 are ignored.

Verification
REQ-031 Single byte: CLKS_PER_BIT=87, write 0x55 at edge N -> line low for edges N+2..N+88, then bits 1,0,1,0,1,0,1,0 at 87 cycles each, then high. o_Tx_Done pulses once at N+872.
REQ-032 Fill and overflow: FIFO_DEPTH=4, write 0x01..0x05 on consecutive cycles while a frame is active -> 0x05 is dropped, o_Tx_Ready=0, count=4. The line emits 0x01..0x04 in order.
REQ-033 Back-to-back: queue 0xA3 and 0x3C -> exactly 2 high cycles between the first stop bit and the second start bit. Sampled bytes match.
REQ-034 Simultaneous push/pop: count=1 and idle, write 0x7E in the pop cycle -> count stays 1, and 0x7E is sent after the first byte.
REQ-035 Reset mid-frame: assert rst during bit 3 of 0xFF with 2 bytes queued -> the next edge has Serial=1, Active=0 and count=0, and no o_Tx_Done pulse occurs.
REQ-036 Loopback: connect o_Tx_Serial to a uart_rx with an equal CLKS_PER_BIT, send 0x00, 0xFF and 0x96 -> the receiver's data-valid strobe pulses 3 times and delivers those bytes in that order.
